// File: rtl/avalon_writeburst_pkg.sv
// Shared types and constants for the Avalon write-burst master.
// State encodings, data width and boolean helpers.
package avalon_writeburst_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int WB_DATA_W = 56;

  typedef enum logic [1:0] {
    WB_STATE_IDLE  = 2'd0,
    WB_STATE_WRITE = 2'd1,
    WB_STATE_GAP   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/avalon_writeburst_align.sv
// Byte-offset shifter: places request data at its start byte
// within a two-dword window and splits it into beat data.
import avalon_writeburst_pkg::*;

module avalon_writeburst_align (
  input  logic [WB_DATA_W-1:0] data_i,
  input  logic [1:0]           off_i,
  output logic [31:0]          beat0_o,
  output logic [31:0]          beat1_o
);

  logic [63:0] shifted;

  always_comb begin
    shifted = {8'd0, data_i} << {off_i, 3'b000};
    beat0_o = shifted[31:0];
    beat1_o = shifted[63:32];
  end

endmodule

// File: rtl/avalon_writeburst.sv
// Avalon-MM write-burst master: one request -> 1 or 2 beat burst.
// Optional counters with `define WRITEBURST_STATS_EN.
import avalon_writeburst_pkg::*;

module avalon_writeburst #(
  parameter int BURST_W   = 3,
  parameter int ALIGN_REG = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 writeburst_do_i,
  output logic                 writeburst_done_o,
  input  logic [31:0]          writeburst_address_i,
  input  logic [1:0]           writeburst_dword_length_i,
  input  logic [3:0]           writeburst_byteenable_0_i,
  input  logic [3:0]           writeburst_byteenable_1_i,
  input  logic [WB_DATA_W-1:0] writeburst_data_i,
  output logic [29:0]          avm_address_o,
  output logic                 avm_write_o,
  output logic [31:0]          avm_writedata_o,
  output logic [3:0]           avm_byteenable_o,
  output logic [BURST_W-1:0]   avm_burstcount_o,
  input  logic                 avm_waitrequest_i
`ifdef WRITEBURST_STATS_EN
  ,
  output logic [31:0]          stat_burst_count_o,
  output logic [31:0]          stat_wait_cycles_o
`endif
);

  wb_state_e            state_q;
  logic                 write_q;
  logic                 done_q;
  logic [29:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           be_q;
  logic [BURST_W-1:0]   bc_q;
  logic                 len2_q;
  logic                 beat_q;
  logic                 prime_q;
  logic [31:0]          beat1_q;
  logic [3:0]           be0_q;
  logic [3:0]           be1_q;
  logic [WB_DATA_W-1:0] raw_q;
  logic [1:0]           off_q;

  logic [WB_DATA_W-1:0] al_data;
  logic [1:0]           al_off;
  logic [31:0]          al_beat0;
  logic [31:0]          al_beat1;
  logic                 accept;
  logic                 req_len2;

  // Registered alignment shifts from latched fields one cycle later
  assign al_data  = (ALIGN_REG != 0) ? raw_q : writeburst_data_i;
  assign al_off   = (ALIGN_REG != 0) ? off_q
                                     : writeburst_address_i[1:0];
  assign accept   = write_q && !avm_waitrequest_i;
  assign req_len2 = writeburst_dword_length_i[1];

  avalon_writeburst_align u_align (
    .data_i  (al_data),
    .off_i   (al_off),
    .beat0_o (al_beat0),
    .beat1_o (al_beat1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WB_STATE_IDLE;
      write_q <= FALSE;
      done_q  <= FALSE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      bc_q    <= '0;
      len2_q  <= FALSE;
      beat_q  <= FALSE;
      prime_q <= FALSE;
      beat1_q <= '0;
      be0_q   <= '0;
      be1_q   <= '0;
      raw_q   <= '0;
      off_q   <= '0;
    end else begin
      done_q <= FALSE;
      unique case (state_q)
        WB_STATE_IDLE: begin
          if (writeburst_do_i) begin
            assert (writeburst_dword_length_i != 2'd3)
              else $warning("dword_length 3 out of contract, issuing 2 beats");
            addr_q  <= writeburst_address_i[31:2];
            bc_q    <= req_len2 ? BURST_W'(2) : BURST_W'(1);
            len2_q  <= req_len2;
            beat_q  <= FALSE;
            be0_q   <= writeburst_byteenable_0_i;
            be1_q   <= writeburst_byteenable_1_i;
            raw_q   <= writeburst_data_i;
            off_q   <= writeburst_address_i[1:0];
            state_q <= WB_STATE_WRITE;
            if (ALIGN_REG != 0) begin
              prime_q <= TRUE;
            end else begin
              wdata_q <= al_beat0;
              beat1_q <= al_beat1;
              be_q    <= writeburst_byteenable_0_i;
              write_q <= TRUE;
            end
          end
        end
        WB_STATE_WRITE: begin
          if (prime_q) begin
            prime_q <= FALSE;
            wdata_q <= al_beat0;
            beat1_q <= al_beat1;
            be_q    <= be0_q;
            write_q <= TRUE;
          end else if (accept) begin
            if (len2_q && !beat_q) begin
              beat_q  <= TRUE;
              wdata_q <= beat1_q;
              be_q    <= be1_q;
            end else begin
              write_q <= FALSE;
              done_q  <= TRUE;
              state_q <= WB_STATE_GAP;
            end
          end
        end
        WB_STATE_GAP: begin
          // Upstream still shows do here; ignore it
          state_q <= WB_STATE_IDLE;
        end
        default: state_q <= WB_STATE_IDLE;
      endcase
    end
  end

  assign writeburst_done_o = done_q;
  assign avm_address_o     = addr_q;
  assign avm_write_o       = write_q;
  assign avm_writedata_o   = wdata_q;
  assign avm_byteenable_o  = be_q;
  assign avm_burstcount_o  = bc_q;

`ifdef WRITEBURST_STATS_EN
  logic [31:0] bursts_q;
  logic [31:0] waits_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bursts_q <= '0;
      waits_q  <= '0;
    end else begin
      if (done_q) bursts_q <= bursts_q + 32'd1;
      if (write_q && avm_waitrequest_i)
        waits_q <= waits_q + 32'd1;
    end
  end

  assign stat_burst_count_o = bursts_q;
  assign stat_wait_cycles_o = waits_q;
`endif

endmodule

// File: tb/tb_avalon_writeburst.sv
// Scoreboard bench for avalon_writeburst.
// Honours `define WRITEBURST_STATS_EN for counter checks.
module tb_avalon_writeburst;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_do;
  logic        wb_done;
  logic [31:0] wb_addr;
  logic [1:0]  wb_len;
  logic [3:0]  wb_be0;
  logic [3:0]  wb_be1;
  logic [55:0] wb_data;
  logic [29:0] avm_addr;
  logic        avm_write;
  logic [31:0] avm_wdata;
  logic [3:0]  avm_be;
  logic [2:0]  avm_bc;
  logic        waitreq;
`ifdef WRITEBURST_STATS_EN
  logic [31:0] stat_bursts;
  logic [31:0] stat_waits;
`endif

  always #5 clk = ~clk;

  avalon_writeburst #(
    .BURST_W   (3),
    .ALIGN_REG (0)
  ) dut (
    .clk                       (clk),
    .rst                       (rst),
    .writeburst_do_i           (wb_do),
    .writeburst_done_o         (wb_done),
    .writeburst_address_i      (wb_addr),
    .writeburst_dword_length_i (wb_len),
    .writeburst_byteenable_0_i (wb_be0),
    .writeburst_byteenable_1_i (wb_be1),
    .writeburst_data_i         (wb_data),
    .avm_address_o             (avm_addr),
    .avm_write_o               (avm_write),
    .avm_writedata_o           (avm_wdata),
    .avm_byteenable_o          (avm_be),
    .avm_burstcount_o          (avm_bc),
    .avm_waitrequest_i         (waitreq)
`ifdef WRITEBURST_STATS_EN
    ,
    .stat_burst_count_o        (stat_bursts),
    .stat_wait_cycles_o        (stat_waits)
`endif
  );

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  be;
    logic [2:0]  bc;
  } beat_t;

  beat_t sb[$];
  int    stallq[$];
  int    stall_cur = 0;
  int    total = 0;
  int    bad = 0;
  int    done_cnt = 0;
  int    wcnt = 0;
  int    bursts_m = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Slave model: per-beat stall counts
  always @(posedge clk) begin
    if (avm_write === 1'b1 && waitreq) begin
      stall_cur--;
    end else if (avm_write === 1'b1) begin
      stall_cur = (stallq.size() > 0) ? stallq.pop_front() : 0;
    end
    #1;
    waitreq = (avm_write === 1'b1) && (stall_cur > 0);
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (wb_done === 1'b1) done_cnt++;
      if (avm_write === 1'b1 && waitreq) begin
        wcnt++;
        if (sb.size() > 0) begin
          chk("hold_data", avm_wdata, sb[0].d);
          chk("hold_be", avm_be, sb[0].be);
        end
      end
      if (avm_write === 1'b1 && !waitreq) begin
        if (sb.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          chk("addr", avm_addr, sb[0].a);
          chk("wdata", avm_wdata, sb[0].d);
          chk("be", avm_be, sb[0].be);
          chk("bcount", avm_bc, sb[0].bc);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic push_req(input logic [31:0] a,
                          input logic [1:0]  len,
                          input logic [3:0]  b0,
                          input logic [3:0]  b1,
                          input logic [55:0] d,
                          input int          s0,
                          input int          s1,
                          output int         nb);
    logic [63:0] sh;
    beat_t       bt;
    sh = {8'd0, d} << (8 * a[1:0]);
    nb = (len >= 2'd2) ? 2 : 1;
    bt.a  = a[31:2];
    bt.bc = 3'(nb);
    bt.d  = sh[31:0];
    bt.be = b0;
    sb.push_back(bt);
    if (nb == 2) begin
      bt.d  = sh[63:32];
      bt.be = b1;
      sb.push_back(bt);
    end
    stall_cur = s0;
    stallq.delete();
    if (nb == 2) stallq.push_back(s1);
    wb_addr = a;
    wb_len  = len;
    wb_be0  = b0;
    wb_be1  = b1;
    wb_data = d;
    wb_do   = 1'b1;
  endtask

  task automatic req(input logic [31:0] a,
                     input logic [1:0]  len,
                     input logic [3:0]  b0,
                     input logic [3:0]  b1,
                     input logic [55:0] d,
                     input int          s0,
                     input int          s1,
                     input bit          chk_lat);
    int nb;
    int n;
    int dn0;
    @(negedge clk);
    dn0 = done_cnt;
    push_req(a, len, b0, b1, d, s0, s1, nb);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wb_done !== 1'b1 && n < 40);
    if (n >= 40) chk("timeout", 0, 1);
    if (chk_lat) chk("latency", n, nb + 1);
    // Keep do asserted through the gap cycle
    @(negedge clk);
    chk("gap_nowrite", avm_write, 0);
    wb_do = 1'b0;
    wb_addr = $urandom;
    wb_data = {$urandom, $urandom};
    @(negedge clk);
    chk("done_once", done_cnt - dn0, 1);
    chk("sb_empty", sb.size(), 0);
    bursts_m++;
  endtask

  initial begin
    int nb;
    int n;
    int dn0;
    rst = 1'b1;
    wb_do = 1'b0;
    wb_addr = '0;
    wb_len = '0;
    wb_be0 = '0;
    wb_be1 = '0;
    wb_data = '0;
    waitreq = 1'b0;
    #1;
    chk("rst_write", avm_write, 0);
    chk("rst_addr", avm_addr, 0);
    chk("rst_wdata", avm_wdata, 0);
    chk("rst_be", avm_be, 0);
    chk("rst_bc", avm_bc, 0);
    chk("rst_done", wb_done, 0);
`ifdef WRITEBURST_STATS_EN
    chk("rst_sb", stat_bursts, 0);
    chk("rst_sw", stat_waits, 0);
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    req(32'h1000, 2'd1, 4'hF, 4'h0,
        56'h00_0000_DDCCBBAA, 0, 0, 1'b1);
    req(32'h2003, 2'd2, 4'h8, 4'h7,
        56'h0000_0044332211, 0, 0, 1'b1);
    req(32'h3001, 2'd2, 4'hE, 4'h1,
        56'h77_6655_4433_2211, 3, 2, 1'b0);
    req(32'h4002, 2'd2, 4'hC, 4'h0,
        56'hAB_CDEF_0123_4567, 0, 0, 1'b1);
    req(32'h5000, 2'd3, 4'hF, 4'hF,
        56'h12_3456_789A_BCDE, 1, 0, 1'b0);
    req(32'h6001, 2'd0, 4'h0, 4'hF,
        56'h00_0000_00C0FFEE, 0, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      req({$urandom} & 32'hFFFF_FFFF, 2'($urandom_range(1, 2)),
          4'($urandom), 4'($urandom),
          {$urandom, $urandom}, $urandom_range(0, 2),
          $urandom_range(0, 2), 1'b0);
    end

    // Reset while beat1 is stalled
    @(negedge clk);
    dn0 = done_cnt;
    push_req(32'h7000, 2'd2, 4'hF, 4'hF,
             56'h11_2222_3333_4444, 0, 5, nb);
    n = 0;
    while (sb.size() > 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("rst_timeout", 0, 1);
    @(negedge clk);
    chk("mid_write", avm_write, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_write", avm_write, 0);
    chk("mid_rst_done", wb_done, 0);
    chk("mid_rst_addr", avm_addr, 0);
    wb_do = 1'b0;
    sb.delete();
    stallq.delete();
    stall_cur = 0;
    wcnt = 0;
    bursts_m = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_done", done_cnt - dn0, 0);
    req(32'h8002, 2'd2, 4'hC, 4'h3,
        56'h00_0000_AABBCCDD, 0, 0, 1'b1);
    req(32'h9000, 2'd1, 4'hF, 4'h0,
        56'h00_0000_01020304, 2, 0, 1'b0);
`ifdef WRITEBURST_STATS_EN
    chk("stat_bursts", stat_bursts, bursts_m);
    chk("stat_waits", stat_waits, wcnt);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
